// File: rtl/mem_bus_arbiter.sv
// Shares one memory/IO bus between the fetch and load/store ports.
// Each access runs IDLE -> BUSY -> DONE; IO-window and timed-out accesses finish locally.
module mem_bus_arbiter #(
  parameter logic [31:0] IO_BASE      = 32'hFFFFFFF0,
  parameter int          TIMEOUT      = 16,
  parameter int          MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err,
  output logic        stall
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          m_read_q, m_read_d;
  logic          m_write_q, m_write_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          bus_err_q, bus_err_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;

  logic d_req;
  logic grant_d;
  logic io_hit;
  logic complete;

  assign d_req    = d_read | d_write;
  // IO registers answer combinationally, so the first BUSY cycle completes.
  assign io_hit   = owner_q & (m_addr_q >= IO_BASE);
  assign complete = m_ack | io_hit;

  always_comb begin
    state_d   = state_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    bus_err_d = 1'b0;
    owner_d   = owner_q;
    streak_d  = streak_q;
    timer_d   = timer_q;
    grant_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          // Fetch wins only once data has starved it MAX_D_STREAK times.
          grant_d = d_req & ~(i_req & (streak_q == S_MAX));
          owner_d = grant_d;
          timer_d = '0;
          state_d = S_BUSY;
          if (grant_d) begin
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_write_d = d_write;
            m_read_d  = ~d_write;
            if (!i_req)
              streak_d = '0;
            else if (streak_q != S_MAX)
              streak_d = streak_q + 1'b1;
          end else begin
            m_addr_d  = i_addr;
            m_write_d = 1'b0;
            m_read_d  = 1'b1;
            streak_d  = '0;
          end
        end
      end

      S_BUSY: begin
        timer_d = timer_q + 1'b1;
        if (complete) begin
          if (owner_q)
            d_rdata_d = m_write_q ? 32'h0 : m_rdata;
          else
            i_rdata_d = m_rdata;
          i_done_d  = ~owner_q;
          d_done_d  = owner_q;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = S_DONE;
        end else if (timer_q == T_LAST) begin
          if (owner_q)
            d_rdata_d = 32'h0;
          else
            i_rdata_d = 32'h0;
          i_done_d  = ~owner_q;
          d_done_d  = owner_q;
          bus_err_d = 1'b1;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
      owner_q   <= 1'b0;
      streak_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      bus_err_q <= bus_err_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      timer_q   <= timer_d;
    end
  end

  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign bus_err = bus_err_q;
  assign stall   = (i_req & ~i_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: data-port vector table plus
// hand-written fetch, contention and reset-mid-access sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_err;
  logic        stall;

  logic ack_auto;
  logic ack_man;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_ack = ack_auto ? (m_read | m_write) : ack_man;

  mem_bus_arbiter #(
    .IO_BASE(32'hFFFFFFF0),
    .TIMEOUT(16),
    .MAX_D_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_done(i_done),
    .d_read(d_read),
    .d_write(d_write),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done(d_done),
    .m_read(m_read),
    .m_write(m_write),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack(m_ack),
    .bus_err(bus_err),
    .stall(stall)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    logic        exp_wr;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int cyc;
    int ipulses;
    bit done;
    @(negedge clk);
    d_read  = v.rd;
    d_write = v.wr;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    m_rdata = v.rdata;
    ack_man = 1'b0;
    cyc = 0;
    ipulses = 0;
    done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(posedge clk);
      #1;
      if (i_done) ipulses++;
      if (m_read | m_write) begin
        cyc++;
        if (cyc == 1) begin
          chk($sformatf("v%0d_mwrite", k), m_write, v.exp_wr);
          chk($sformatf("v%0d_mread", k), m_read, !v.exp_wr);
          chk($sformatf("v%0d_maddr", k), m_addr, v.addr);
          if (v.exp_wr)
            chk($sformatf("v%0d_mwdata", k), m_wdata, v.wdata);
        end
        ack_man = (cyc == v.ack_at);
      end else begin
        ack_man = 1'b0;
      end
      if (d_done) begin
        done = 1;
        chk($sformatf("v%0d_cycles", k), cyc, v.exp_cyc);
        chk($sformatf("v%0d_drdata", k), d_rdata, v.exp_rdata);
        chk($sformatf("v%0d_buserr", k), bus_err, v.exp_err);
        chk($sformatf("v%0d_stall_done", k), stall, 0);
      end
    end
    chk($sformatf("v%0d_done_seen", k), done, 1);
    chk($sformatf("v%0d_no_idone", k), ipulses, 0);
    d_read  = 1'b0;
    d_write = 1'b0;
    ack_man = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_idle_after", k), {m_read, m_write, d_done, bus_err}, 0);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a,
                          input logic [31:0] rd, input int ack_at,
                          input int exp_edges, input int exp_cyc);
    int edges;
    int cyc;
    bit done;
    @(negedge clk);
    i_req   = 1'b1;
    i_addr  = a;
    m_rdata = rd;
    ack_man = 1'b0;
    #1;
    chk({tag, "_stall_req"}, stall, 1);
    edges = 0;
    cyc = 0;
    done = 0;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (m_read) begin
        cyc++;
        if (cyc == 1) chk({tag, "_maddr"}, m_addr, a);
        ack_man = (cyc == ack_at);
      end else begin
        ack_man = 1'b0;
      end
      if (i_done) begin
        done = 1;
        chk({tag, "_latency"}, edges, exp_edges);
        chk({tag, "_mread_cycles"}, cyc, exp_cyc);
        chk({tag, "_irdata"}, i_rdata, rd);
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_ddone"}, d_done, 0);
      end
    end
    chk({tag, "_done_seen"}, done, 1);
    i_req   = 1'b0;
    ack_man = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_pulse_one"}, i_done, 0);
    chk({tag, "_irdata_hold"}, i_rdata, rd);
  endtask

  initial begin
    int g[10];
    int exp_g[10];
    int n;
    logic prev;

    tv[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'h11111111, 1,
              1'b0, 1, 32'h11111111, 1'b0};
    tv[1] = '{1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFEBABE, 3,
              1'b0, 3, 32'hCAFEBABE, 1'b0};
    tv[2] = '{1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h99999999, 2,
              1'b1, 2, 32'h0, 1'b0};
    tv[3] = '{1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 32'h12345678, 0,
              1'b0, 1, 32'h12345678, 1'b0};
    tv[4] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hA5, 32'h55555555, 0,
              1'b1, 1, 32'h0, 1'b0};
    tv[5] = '{1'b1, 1'b0, 32'hFFFFFFEF, 32'h0, 32'h0BADF00D, 2,
              1'b0, 2, 32'h0BADF00D, 1'b0};
    tv[6] = '{1'b1, 1'b0, 32'h2000, 32'h0, 32'h77777777, 0,
              1'b0, 16, 32'h0, 1'b1};
    tv[7] = '{1'b1, 1'b0, 32'h3000, 32'h0, 32'h600DCAFE, 16,
              1'b0, 16, 32'h600DCAFE, 1'b0};
    tv[8] = '{1'b1, 1'b1, 32'h40, 32'h77, 32'h44444444, 1,
              1'b1, 1, 32'h0, 1'b0};

    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst      = 1'b1;
    i_req    = 1'b0;
    i_addr   = '0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    m_rdata  = '0;
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {m_read, m_write, i_done, d_done, bus_err}, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mwdata", m_wdata, 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;

    do_fetch("fetch", 32'h100, 32'h00500093, 2, 3, 2);

    for (int k = 0; k < 9; k++) run_vec(k, tv[k]);

    // Contention: both ports hold requests, memory acks immediately.
    @(negedge clk);
    i_addr   = 32'h100;
    d_addr   = 32'h200;
    m_rdata  = 32'h13;
    i_req    = 1'b1;
    d_read   = 1'b1;
    ack_auto = 1'b1;
    n = 0;
    prev = 1'b0;
    for (int t = 0; t < 100 && n < 10; t++) begin
      @(posedge clk);
      #1;
      if (m_read && !prev) begin
        g[n] = (m_addr == 32'h200) ? 1 : 0;
        n++;
      end
      prev = m_read;
    end
    chk("cont_grants", n, 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("cont_grant%0d", k), g[k], exp_g[k]);
    i_req  = 1'b0;
    d_read = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ack_auto = 1'b0;
    chk("cont_idle", {m_read, m_write, i_done, d_done}, 0);

    // Reset in the middle of a fetch that never gets acked.
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h300;
    m_rdata = 32'h33;
    repeat (3) @(posedge clk);
    #1;
    chk("rmid_busy", m_read, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_strobe", {m_read, m_write}, 0);
    chk("rmid_nodone", {i_done, d_done, bus_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b0;
    ack_man = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_lateack", {m_read, i_done, d_done}, 0);
    @(negedge clk);
    ack_man = 1'b0;
    @(posedge clk);
    #1;
    chk("rmid_quiet", {m_read, i_done, d_done}, 0);
    chk("rmid_irdata", i_rdata, 0);

    do_fetch("refetch", 32'h104, 32'h00000013, 1, 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
